// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-address width, the x0 index and the load funct3 encodings.
package cpu_pkg;

   localparam int RA_W = 5;
   localparam logic [RA_W-1:0] X0_IDX = '0;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LD  = 3'b011,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101,
      F3_LWU = 3'b110,
      F3_ILL = 3'b111
   } load_f3_e;

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load formatter: aligns raw memory data to the accessed lane and extends it.
module wb_load_fmt
   import cpu_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int OFF_W = $clog2(XLEN/8)
) (
   input  logic [2:0]       funct3_i,
   input  logic [OFF_W-1:0] addr_low_i,
   input  logic [XLEN-1:0]  memdata_i,
   output logic [XLEN-1:0]  data_o,
   output logic             illegal_o
);

   logic [OFF_W-1:0] lowMask;
   logic [OFF_W-1:0] alignedOff;
   logic [XLEN-1:0]  shifted;

   // Offset bits below the access size are ignored, so misaligned addresses snap down to the lane.
   always_comb begin
      lowMask = '1;
      case (funct3_i[1:0])
         2'd0:    lowMask = '1;
         2'd1:    lowMask = ~OFF_W'(1);
         2'd2:    lowMask = ~OFF_W'(3);
         default: lowMask = ~OFF_W'(7);
      endcase
      alignedOff = addr_low_i & lowMask;
      shifted    = memdata_i >> {alignedOff, 3'b000};
   end

   always_comb begin
      data_o    = '0;
      illegal_o = 1'b0;
      case (load_f3_e'(funct3_i))
         F3_LB:  data_o = XLEN'($signed(shifted[7:0]));
         F3_LH:  data_o = XLEN'($signed(shifted[15:0]));
         F3_LW:  data_o = XLEN'($signed(shifted[31:0]));
         F3_LD: begin
            if (XLEN == 64) begin
               data_o = shifted;
            end else begin
               illegal_o = 1'b1;
            end
         end
         F3_LBU: data_o = XLEN'(shifted[7:0]);
         F3_LHU: data_o = XLEN'(shifted[15:0]);
         F3_LWU: data_o = XLEN'(shifted[31:0]);
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/write_back_arb.sv
// Write-back arbiter: merges the in-order main pipeline with round-robin auxiliary
// completion channels onto the single register-file write port.
module write_back_arb
   import cpu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int NUM_AUX = 2,
   parameter int RA_W    = cpu_pkg::RA_W,
   parameter int OFF_W   = $clog2(XLEN/8),
   parameter int SRC_W   = $clog2(NUM_AUX+1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    regW_i_valid,
   input  logic                    regW_i_is_load,
   input  logic [2:0]              regW_i_funct3,
   input  logic [OFF_W-1:0]        regW_i_addr_low,
   input  logic [XLEN-1:0]         regW_i_alu_result,
   input  logic [XLEN-1:0]         regW_i_memdata,
   input  logic [RA_W-1:0]         regW_i_rd,
   input  logic                    regW_i_reg_wen,
   input  logic [NUM_AUX-1:0]      aux_i_valid,
   output logic [NUM_AUX-1:0]      aux_o_ready,
   input  logic [NUM_AUX*RA_W-1:0] aux_i_rd,
   input  logic [NUM_AUX*XLEN-1:0] aux_i_data,
   output logic [RA_W-1:0]         write_back_o_rd,
   output logic [XLEN-1:0]         write_back_o_data,
   output logic                    write_back_o_reg_wen,
   output logic [SRC_W-1:0]        write_back_o_src,
   output logic                    write_back_o_retire
);

   localparam int PTR_W = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;

   logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
   logic [RA_W-1:0]    rd_q, rd_d;
   logic [XLEN-1:0]    data_q, data_d;
   logic               wen_q, wen_d;
   logic [SRC_W-1:0]   src_q, src_d;
   logic               retire_q, retire_d;

   logic               mainUse;
   logic               grantValid;
   logic [PTR_W-1:0]   grantIdx;
   logic [NUM_AUX-1:0] grantOneHot;
   logic [RA_W-1:0]    grantRd;
   logic [XLEN-1:0]    fmtData;
   logic               fmtIllegal;

   wb_load_fmt #(
      .XLEN  (XLEN),
      .OFF_W (OFF_W)
   ) u_load_fmt (
      .funct3_i   (regW_i_funct3),
      .addr_low_i (regW_i_addr_low),
      .memdata_i  (regW_i_memdata),
      .data_o     (fmtData),
      .illegal_o  (fmtIllegal)
   );

   assign mainUse = regW_i_valid & regW_i_reg_wen & (regW_i_rd != RA_W'(X0_IDX));

   // Round-robin search starting at the pointer; main traffic blocks every aux grant.
   always_comb begin
      grantValid  = 1'b0;
      grantIdx    = '0;
      grantOneHot = '0;
      if (!mainUse) begin
         for (int k = 0; k < NUM_AUX; k++) begin
            if (!grantValid && aux_i_valid[(int'(rrPtr_q) + k) % NUM_AUX]) begin
               grantValid = 1'b1;
               grantIdx   = PTR_W'((int'(rrPtr_q) + k) % NUM_AUX);
            end
         end
      end
      if (grantValid) begin
         grantOneHot[grantIdx] = 1'b1;
      end
   end

   assign aux_o_ready = rst_n ? grantOneHot : '0;
   assign grantRd     = aux_i_rd[grantIdx*RA_W +: RA_W];

   always_comb begin
      rrPtr_d  = rrPtr_q;
      rd_d     = rd_q;
      data_d   = data_q;
      src_d    = src_q;
      wen_d    = 1'b0;
      retire_d = regW_i_valid;
      if (mainUse) begin
         rd_d   = regW_i_rd;
         data_d = regW_i_is_load ? fmtData : regW_i_alu_result;
         wen_d  = !(regW_i_is_load && fmtIllegal);
         src_d  = '0;
      end else if (grantValid) begin
         rd_d    = grantRd;
         data_d  = aux_i_data[grantIdx*XLEN +: XLEN];
         wen_d   = (grantRd != RA_W'(X0_IDX));
         src_d   = SRC_W'(grantIdx) + 1'b1;
         rrPtr_d = (int'(grantIdx) == NUM_AUX-1) ? '0 : grantIdx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrPtr_q  <= '0;
         rd_q     <= '0;
         data_q   <= '0;
         wen_q    <= 1'b0;
         src_q    <= '0;
         retire_q <= 1'b0;
      end else begin
         rrPtr_q  <= rrPtr_d;
         rd_q     <= rd_d;
         data_q   <= data_d;
         wen_q    <= wen_d;
         src_q    <= src_d;
         retire_q <= retire_d;
      end
   end

   assign write_back_o_rd      = rd_q;
   assign write_back_o_data    = data_q;
   assign write_back_o_reg_wen = wen_q;
   assign write_back_o_src     = src_q;
   assign write_back_o_retire  = retire_q;

endmodule
